// File: rtl/carus_clk_gate_ctrl.sv
// Multi-channel auto-idling clock-gate controller.
// Each channel watches its own activity, gates its clock after a
// programmable number of idle cycles, and runs a fixed-length wake
// sequence before reporting ready again. One latch-based ICG per channel.
module carus_clk_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CNT_W  = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scan_cg_en_i,
  input  logic [NUM_CH-1:0]     auto_en_i,
  input  logic [NUM_CH-1:0]     busy_i,
  input  logic [NUM_CH-1:0]     wake_req_i,
  input  logic [IDLE_CNT_W-1:0] idle_thr_i,
  output logic [NUM_CH-1:0]     clk_o,
  output logic [NUM_CH-1:0]     cg_en_o,
  output logic [NUM_CH-1:0]     ready_o,
  output logic [NUM_CH-1:0]     gated_o
);

  localparam int WCW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WCW-1:0] WAKE_ONE  = WCW'(1);
  localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_COUNT,
    ST_GATED,
    ST_WAKE
  } state_e;

  state_e                               state_q [NUM_CH];
  state_e                               state_d [NUM_CH];
  logic   [NUM_CH-1:0][IDLE_CNT_W-1:0]  cnt_q, cnt_d;
  logic   [NUM_CH-1:0][WCW-1:0]         wcnt_q, wcnt_d;
  logic   [NUM_CH-1:0]                  act;

  // A channel counts as active if it is busy, being woken, or not allowed to gate.
  assign act = busy_i | wake_req_i | ~auto_en_i;

  // State and counter registers, synchronous reset to RUN with counters cleared.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // combinational blocks use blocking (=).
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_i) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
        wcnt_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        wcnt_q[i]  <= wcnt_d[i];
      end
    end
  end

  // Per-channel next-state and counter update.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      wcnt_d[i]  = wcnt_q[i];
      unique case (state_q[i])
        ST_RUN: begin
          if (!act[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = '0;
          end
        end
        ST_COUNT: begin
          if (act[i]) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= idle_thr_i) begin
            // The >= compare also stops the counter when the threshold drops mid-count.
            state_d[i] = ST_GATED;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_GATED: begin
          if (act[i]) begin
            state_d[i] = ST_WAKE;
            wcnt_d[i]  = WAKE_ONE;
          end
        end
        ST_WAKE: begin
          // Activity is ignored here; the channel always completes the wake sequence.
          if (wcnt_q[i] == WAKE_LAST) begin
            state_d[i] = ST_RUN;
          end else begin
            wcnt_d[i] = wcnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = ST_RUN;
      endcase
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    cg_en_o = '1;
    ready_o = '1;
    gated_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cg_en_o[i] = (state_q[i] != ST_GATED);
      ready_o[i] = (state_q[i] == ST_RUN) || (state_q[i] == ST_COUNT);
      gated_o[i] = (state_q[i] == ST_GATED);
    end
  end

  // Behavioural ICG per channel: enable captured while the clock is low, ANDed with it.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_icg
    logic en_lat;

    // Transparent-low latch keeps the gated clock glitch-free.
    // NOTE: this latch is intentional; it is written as always_latch so it is explicit.
    always_latch begin
      if (!clk_i) en_lat <= cg_en_o[g] | scan_cg_en_i;
    end

    assign clk_o[g] = clk_i & en_lat;
  end

endmodule

// File: tb/tb_carus_clk_gate_ctrl.sv
// Directed testbench for carus_clk_gate_ctrl with hand-computed expectations.
module tb_carus_clk_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan;
  logic [3:0] auto_en;
  logic [3:0] busy;
  logic [3:0] wake_req;
  logic [7:0] thr;
  logic [3:0] clk_g;
  logic [3:0] cg_en;
  logic [3:0] ready;
  logic [3:0] gated;

  int n_tests = 0;
  int n_fail  = 0;

  carus_clk_gate_ctrl #(
    .NUM_CH      (4),
    .IDLE_CNT_W  (8),
    .WAKE_CYCLES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_cg_en_i (scan),
    .auto_en_i    (auto_en),
    .busy_i       (busy),
    .wake_req_i   (wake_req),
    .idle_thr_i   (thr),
    .clk_o        (clk_g),
    .cg_en_o      (cg_en),
    .ready_o      (ready),
    .gated_o      (gated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; scan = 1'b0; auto_en = 4'b0000; busy = 4'b0000;
    wake_req = 4'b0000; thr = 8'd3;
    step(2);
    check("rst_cg_en", 32'(cg_en), 32'hF);
    check("rst_ready", 32'(ready), 32'hF);
    check("rst_gated", 32'(gated), 32'h0);

    // Reset then idle: ch0 gates exactly 5 edges after release.
    auto_en = 4'b0001; thr = 8'd3;
    rst = 1'b0;
    step(4);
    check("t1_not_yet",  32'(gated), 32'h0);
    step(1);
    check("t1_gated",    32'(gated), 32'h1);
    check("t1_cg_en",    32'(cg_en), 32'hE);
    check("t1_ready",    32'(ready), 32'hE);
    step(1);
    check("t1_clk_o",    32'(clk_g), 32'hE);

    // Idle interrupted by a one-cycle busy pulse.
    thr = 8'd5; auto_en = 4'b0001; busy = 4'b0000; wake_req = 4'b0000;
    do_reset();
    step(4);
    busy = 4'b0001;
    step(1);
    check("t2_pulse_ready", 32'(ready), 32'hF);
    busy = 4'b0000;
    step(6);
    check("t2_still_run", 32'(gated), 32'h0);
    step(1);
    check("t2_gated",     32'(gated), 32'h1);

    // Wake handshake on ch2.
    thr = 8'd1; auto_en = 4'b0101;
    step(2);
    check("t3_pre_gate",  32'(gated), 32'h1);
    step(1);
    check("t3_gated",     32'(gated), 32'h5);
    wake_req = 4'b0100;
    step(1);
    check("t3_wake_cg",   32'(cg_en), 32'hE);
    check("t3_wake_rdy",  32'(ready), 32'hA);
    check("t3_wake_gtd",  32'(gated), 32'h1);
    step(1);
    check("t3_wake2_rdy", 32'(ready), 32'hA);
    check("t3_clk2",      32'(clk_g[2]), 32'h1);
    step(1);
    check("t3_ready",     32'(ready), 32'hE);
    step(1);
    check("t3_held_run",  32'(ready), 32'hE);
    wake_req = 4'b0000;
    step(2);
    check("t3_regate_no", 32'(gated), 32'h1);
    step(1);
    check("t3_regate",    32'(gated), 32'h5);

    // Threshold lowered mid-count on ch1.
    thr = 8'd200; auto_en = 4'b0111;
    step(51);
    check("t4_cnt50",     32'(gated), 32'h5);
    thr = 8'd10;
    step(1);
    check("t4_low_thr",   32'(gated), 32'h7);

    // Reset in the middle of a ch1 wake.
    wake_req = 4'b0010;
    step(1);
    check("t5_wake_rdy",  32'(ready), 32'h8);
    check("t5_wake_cg",   32'(cg_en), 32'hA);
    rst = 1'b1;
    step(1);
    check("t5_rst_cg",    32'(cg_en), 32'hF);
    check("t5_rst_rdy",   32'(ready), 32'hF);
    check("t5_rst_gtd",   32'(gated), 32'h0);
    rst = 1'b0; wake_req = 4'b0000; auto_en = 4'b1000; thr = 8'd0;

    // Threshold 0 on ch3, then scan forces its clock.
    step(1);
    check("t5_thr0_cnt",  32'(gated), 32'h0);
    step(1);
    check("t5_thr0_gtd",  32'(gated), 32'h8);
    step(1);
    check("t5_clk_off",   32'(clk_g), 32'h7);
    scan = 1'b1;
    step(1);
    check("t5_scan_hi",   32'(clk_g), 32'hF);
    check("t5_scan_gtd",  32'(gated), 32'h8);
    @(negedge clk); #1;
    check("t5_scan_lo",   32'(clk_g), 32'h0);
    scan = 1'b0;

    // Simultaneous events on ch0, ch1 and ch2.
    auto_en = 4'b0010; busy = 4'b0000; thr = 8'd0; wake_req = 4'b0000;
    do_reset();
    step(2);
    check("t6_ch1_gtd",   32'(gated), 32'h2);
    auto_en = 4'b0111;
    step(1);
    check("t6_pre_gtd",   32'(gated), 32'h2);
    check("t6_pre_rdy",   32'(ready), 32'hD);
    auto_en = 4'b0011; wake_req = 4'b0010;
    step(1);
    check("t6_sim_gtd",   32'(gated), 32'h1);
    check("t6_sim_cg",    32'(cg_en), 32'hE);
    check("t6_sim_rdy",   32'(ready), 32'hC);
    step(2);
    check("t6_end_rdy",   32'(ready), 32'hE);
    check("t6_end_gtd",   32'(gated), 32'h1);
    wake_req = 4'b0000;

    // Maximum threshold: counter reaches 255 without wrapping.
    auto_en = 4'b0001; thr = 8'd255;
    do_reset();
    step(256);
    check("t7_max_cnt",   32'(gated), 32'h0);
    step(1);
    check("t7_max_gtd",   32'(gated), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
